// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the LCD timing generator: panel IDs,
// the timing-set record, FSM state encoding and the colour-bar palette.
package lcd_timing_pkg;

    localparam logic [15:0] LCD_ID_4342 = 16'h4342;
    localparam logic [15:0] LCD_ID_7084 = 16'h7084;
    localparam logic [15:0] LCD_ID_7016 = 16'h7016;
    localparam logic [15:0] LCD_ID_1018 = 16'h1018;

    // One panel's timing: sync / back porch / active / front porch / total.
    typedef struct packed {
        logic [10:0] h_sync;
        logic [10:0] h_back;
        logic [10:0] h_disp;
        logic [10:0] h_front;
        logic [10:0] h_total;
        logic [10:0] v_sync;
        logic [10:0] v_back;
        logic [10:0] v_disp;
        logic [10:0] v_front;
        logic [10:0] v_total;
    } timing_t;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // RGB565 colour of each vertical test bar, left to right.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;  // white
            3'd1:    bar_color = 16'hFFE0;  // yellow
            3'd2:    bar_color = 16'h07FF;  // cyan
            3'd3:    bar_color = 16'h07E0;  // green
            3'd4:    bar_color = 16'hF81F;  // magenta
            3'd5:    bar_color = 16'hF800;  // red
            3'd6:    bar_color = 16'h001F;  // blue
            default: bar_color = 16'h0000;  // black
        endcase
    endfunction

endpackage

// File: rtl/lcd_timing_if.sv
// Bus between the timing generator (master), the display stage and the panel.
// test_pat_en exists only when LCD_TIMING_TEST_PATTERN_EN is defined.
interface lcd_timing_if;

    logic [15:0] lcd_data;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic        lcd_bl;
    logic        lcd_rst;
    logic [15:0] lcd_rgb;
    logic        frame_start;
`ifdef LCD_TIMING_TEST_PATTERN_EN
    logic        test_pat_en;
`endif

    modport master (
        input  lcd_data,
`ifdef LCD_TIMING_TEST_PATTERN_EN
        input  test_pat_en,
`endif
        output pixel_xpos, pixel_ypos, h_disp, v_disp,
        output lcd_hs, lcd_vs, lcd_de, lcd_bl, lcd_rst, lcd_rgb, frame_start
    );

    modport slave (
        output lcd_data,
`ifdef LCD_TIMING_TEST_PATTERN_EN
        output test_pat_en,
`endif
        input  pixel_xpos, pixel_ypos, h_disp, v_disp,
        input  lcd_hs, lcd_vs, lcd_de, lcd_bl, lcd_rst, lcd_rgb, frame_start
    );

endinterface

// File: rtl/lcd_timing_rom.sv
// Combinational panel-ID to timing-set lookup; unknown IDs fall back to 800x480.
module lcd_timing_rom
    import lcd_timing_pkg::*;
(
    input  logic [15:0] lcd_id,
    output timing_t     tset
);

    // Pick the timing set for the attached panel.
    always_comb begin
        tset = '{11'd128, 11'd88, 11'd800, 11'd40, 11'd1056,
                 11'd2, 11'd33, 11'd480, 11'd10, 11'd525};
        case (lcd_id)
            LCD_ID_4342: tset = '{11'd41, 11'd2, 11'd480, 11'd2, 11'd525,
                                  11'd10, 11'd2, 11'd272, 11'd2, 11'd286};
            LCD_ID_7016: tset = '{11'd20, 11'd140, 11'd1024, 11'd160, 11'd1344,
                                  11'd3, 11'd20, 11'd600, 11'd12, 11'd635};
            LCD_ID_1018: tset = '{11'd10, 11'd80, 11'd1280, 11'd70, 11'd1440,
                                  11'd3, 11'd10, 11'd800, 11'd10, 11'd823};
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD timing generator: panel reset, timing-set latch and free-running
// sync/DE counters. Optional colour-bar generator under the macro
// LCD_TIMING_TEST_PATTERN_EN (disabled by default).
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter logic        HS_POL        = 1'b0,
    parameter logic        VS_POL        = 1'b0,
    parameter logic [15:0] PANEL_RST_CYC = 16'd1000
) (
    input  logic         lcd_clk,
    input  logic         sys_rst_n,
    input  logic [15:0]  lcd_id,
    lcd_timing_if.master lcd
);

    state_t      state, state_nxt;
    logic [15:0] rst_cnt;
    logic [10:0] h_cnt, v_cnt, h_nxt, v_nxt;
    timing_t     tset, rom_set;
    logic        run, line_end, frame_end, bl_q, de;
    logic        h_act, v_act, h_req;
    logic [10:0] h_act_start, h_act_end, v_act_start, v_act_end;
    logic        unused_porch;

    lcd_timing_rom u_rom (
        .lcd_id (lcd_id),
        .tset   (rom_set)
    );

    assign run       = (state == ST_RUN);
    assign line_end  = (h_cnt == tset.h_total - 11'd1);
    assign frame_end = line_end && (v_cnt == tset.v_total - 11'd1);
    // Front porches are implied by the totals.
    assign unused_porch = ^{tset.h_front, tset.v_front};

    // FSM state register.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_RST;
        else            state <= state_nxt;
    end

    // RST holds the panel in reset for PANEL_RST_CYC cycles, LOAD is one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:  if (({1'b0, rst_cnt} + 17'd1) >= {1'b0, PANEL_RST_CYC})
                         state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_RST;
        endcase
    end

    // Panel reset duration counter.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)          rst_cnt <= '0;
        else if (state == ST_RST) rst_cnt <= rst_cnt + 16'd1;
        else                      rst_cnt <= '0;
    end

    // Next horizontal/vertical position; both stay at 0 outside RUN.
    always_comb begin
        h_nxt = '0;
        v_nxt = '0;
        if (run) begin
            if (line_end) begin
                h_nxt = '0;
                v_nxt = (v_cnt == tset.v_total - 11'd1) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_nxt = h_cnt + 11'd1;
                v_nxt = v_cnt;
            end
        end
    end

    // Position counters.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Timing set is captured in LOAD and at the last pixel of each frame,
    // so an ID change never disturbs a frame in progress.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                           tset <= '0;
        else if (state == ST_LOAD || (run && frame_end)) tset <= rom_set;
    end

    // Backlight comes on once the first full frame has been sent.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)            bl_q <= 1'b0;
        else if (run && frame_end) bl_q <= 1'b1;
    end

    assign h_act_start = tset.h_sync + tset.h_back;
    assign h_act_end   = h_act_start + tset.h_disp;
    assign v_act_start = tset.v_sync + tset.v_back;
    assign v_act_end   = v_act_start + tset.v_disp;

    assign h_act = (h_cnt >= h_act_start) && (h_cnt < h_act_end);
    assign v_act = (v_cnt >= v_act_start) && (v_cnt < v_act_end);
    // Request window leads the active window by one cycle to cover the
    // display stage's one-cycle read latency.
    assign h_req = (h_cnt >= h_act_start - 11'd1) && (h_cnt < h_act_end - 11'd1);
    assign de    = run && h_act && v_act;

    assign lcd.lcd_de      = de;
    assign lcd.lcd_hs      = (run && h_cnt < tset.h_sync) ? HS_POL : ~HS_POL;
    assign lcd.lcd_vs      = (run && v_cnt < tset.v_sync) ? VS_POL : ~VS_POL;
    assign lcd.pixel_xpos  = (run && h_req && v_act) ? (h_cnt + 11'd1 - h_act_start) : 11'd0;
    assign lcd.pixel_ypos  = (run && v_act) ? (v_cnt - v_act_start + 11'd1) : 11'd0;
    assign lcd.frame_start = run && (h_cnt == 11'd0) && (v_cnt == 11'd0);
    assign lcd.lcd_rst     = (state != ST_RST);
    assign lcd.lcd_bl      = bl_q;
    assign lcd.h_disp      = tset.h_disp;
    assign lcd.v_disp      = tset.v_disp;

`ifdef LCD_TIMING_TEST_PATTERN_EN
    logic [13:0] h_off8;
    logic [2:0]  bar_idx;

    // Bar index = floor(x*8/H_DISP), found by comparing against the 7 bar edges.
    always_comb begin
        h_off8  = {h_cnt - h_act_start, 3'b000};
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_off8 >= 14'(k) * {3'b000, tset.h_disp}) bar_idx = 3'(k);
        end
    end

    // Pixel bus: colour bars or display data, blanked outside DE.
    always_comb begin
        lcd.lcd_rgb = 16'h0000;
        if (de) lcd.lcd_rgb = lcd.test_pat_en ? bar_color(bar_idx) : lcd.lcd_data;
    end
`else
    // Pixel bus: display data, blanked outside DE.
    always_comb begin
        lcd.lcd_rgb = 16'h0000;
        if (de) lcd.lcd_rgb = lcd.lcd_data;
    end
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed testbench for lcd_timing_gen (PANEL_RST_CYC = 16, default polarities).
module tb_lcd_timing_gen;
    import lcd_timing_pkg::*;

    logic        lcd_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] lcd_id    = LCD_ID_7084;
    int          n_checks  = 0;
    int          n_fail    = 0;

    lcd_timing_if bus();

    lcd_timing_gen #(.PANEL_RST_CYC(16'd16)) dut (
        .lcd_clk   (lcd_clk),
        .sys_rst_n (sys_rst_n),
        .lcd_id    (lcd_id),
        .lcd       (bus)
    );

    always #5 lcd_clk = ~lcd_clk;

    // Release reset and count cycles until the panel reset output goes high.
    task automatic release_and_wait_rst(output int cyc);
        sys_rst_n = 1'b1;
        cyc = 0;
        while (bus.lcd_rst !== 1'b1 && cyc < 100) begin
            @(negedge lcd_clk);
            cyc++;
        end
    endtask

    // Cycles until the next falling edge of lcd_hs (start of the next line).
    task automatic count_hs_period(input int bound, output int cyc);
        logic prev;
        prev = bus.lcd_hs;
        cyc  = 0;
        while (cyc < bound) begin
            @(negedge lcd_clk);
            cyc++;
            if (bus.lcd_hs === 1'b0 && prev === 1'b1) break;
            prev = bus.lcd_hs;
        end
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        lcd_id = LCD_ID_7084;
        bus.lcd_data = 16'hF800;
        repeat (3) @(negedge lcd_clk);
        n_checks++; if (bus.lcd_rst !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_rst: got %b expected 0", bus.lcd_rst); end
        n_checks++; if (bus.lcd_bl !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_bl: got %b expected 0", bus.lcd_bl); end
        n_checks++; if (bus.lcd_de !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_de: got %b expected 0", bus.lcd_de); end
        n_checks++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", bus.frame_start); end
        n_checks++; if (bus.lcd_hs !== 1'b1) begin n_fail++; $display("FAIL reset_lcd_hs: got %b expected 1", bus.lcd_hs); end
        n_checks++; if (bus.lcd_vs !== 1'b1) begin n_fail++; $display("FAIL reset_lcd_vs: got %b expected 1", bus.lcd_vs); end
        n_checks++; if (bus.lcd_rgb !== 16'h0000) begin n_fail++; $display("FAIL reset_lcd_rgb: got %h expected 0000", bus.lcd_rgb); end
        n_checks++; if (bus.pixel_xpos !== 11'd0) begin n_fail++; $display("FAIL reset_xpos: got %0d expected 0", bus.pixel_xpos); end
        n_checks++; if (bus.pixel_ypos !== 11'd0) begin n_fail++; $display("FAIL reset_ypos: got %0d expected 0", bus.pixel_ypos); end
        n_checks++; if (bus.h_disp !== 11'd0) begin n_fail++; $display("FAIL reset_h_disp: got %0d expected 0", bus.h_disp); end
        n_checks++; if (bus.v_disp !== 11'd0) begin n_fail++; $display("FAIL reset_v_disp: got %0d expected 0", bus.v_disp); end
    endtask

    task automatic test_startup_7084;
        int cyc;
        release_and_wait_rst(cyc);
        n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL lcd_rst_rise: got cycle %0d expected 16", cyc); end
        n_checks++; if (bus.h_disp !== 11'd0) begin n_fail++; $display("FAIL load_h_disp: got %0d expected 0", bus.h_disp); end
        @(negedge lcd_clk);
        n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL run_frame_start: got %b expected 1", bus.frame_start); end
        n_checks++; if (bus.h_disp !== 11'd800) begin n_fail++; $display("FAIL run_h_disp_7084: got %0d expected 800", bus.h_disp); end
        n_checks++; if (bus.v_disp !== 11'd480) begin n_fail++; $display("FAIL run_v_disp_7084: got %0d expected 480", bus.v_disp); end
        n_checks++; if (bus.lcd_hs !== 1'b0 || bus.lcd_vs !== 1'b0) begin n_fail++; $display("FAIL run_sync_active: got hs=%b vs=%b expected 0 0", bus.lcd_hs, bus.lcd_vs); end
    endtask

    task automatic test_first_de_7084;
        int cyc;
        logic [10:0] prev_x, max_x;
        logic [15:0] prev_rgb;
        logic bl_seen;
        cyc = 0; prev_x = '0; prev_rgb = '0; bl_seen = 1'b0; max_x = '0;
        while (bus.lcd_de !== 1'b1 && cyc < 40000) begin
            prev_x = bus.pixel_xpos;
            prev_rgb = bus.lcd_rgb;
            bl_seen = bl_seen | bus.lcd_bl;
            @(negedge lcd_clk);
            cyc++;
        end
        // h=216, v=35 is 35*1056+216 cycles after frame start
        n_checks++; if (cyc != 37176) begin n_fail++; $display("FAIL first_de_7084: got cycle %0d expected 37176", cyc); end
        n_checks++; if (prev_x !== 11'd0) begin n_fail++; $display("FAIL xpos_before_de: got %0d expected 0", prev_x); end
        n_checks++; if (prev_rgb !== 16'h0000) begin n_fail++; $display("FAIL rgb_blank: got %h expected 0000", prev_rgb); end
        n_checks++; if (bl_seen !== 1'b0) begin n_fail++; $display("FAIL bl_early: got %b expected 0", bl_seen); end
        n_checks++; if (bus.pixel_xpos !== 11'd1) begin n_fail++; $display("FAIL xpos_at_de: got %0d expected 1", bus.pixel_xpos); end
        n_checks++; if (bus.pixel_ypos !== 11'd1) begin n_fail++; $display("FAIL ypos_first_line: got %0d expected 1", bus.pixel_ypos); end
        n_checks++; if (bus.lcd_rgb !== 16'hF800) begin n_fail++; $display("FAIL rgb_active: got %h expected f800", bus.lcd_rgb); end
        cyc = 0;
        while (bus.lcd_de === 1'b1 && cyc < 2000) begin
            if (bus.pixel_xpos > max_x) max_x = bus.pixel_xpos;
            @(negedge lcd_clk);
            cyc++;
        end
        n_checks++; if (cyc != 800) begin n_fail++; $display("FAIL de_width_7084: got %0d expected 800", cyc); end
        n_checks++; if (max_x !== 11'd799) begin n_fail++; $display("FAIL xpos_max_7084: got %0d expected 799", max_x); end
        n_checks++; if (bus.lcd_rgb !== 16'h0000) begin n_fail++; $display("FAIL rgb_after_de: got %h expected 0000", bus.lcd_rgb); end
        count_hs_period(2000, cyc);
        n_checks++; if (cyc != 40) begin n_fail++; $display("FAIL tail_to_hs: got %0d expected 40", cyc); end
        count_hs_period(2000, cyc);
        n_checks++; if (cyc != 1056) begin n_fail++; $display("FAIL line_period_7084: got %0d expected 1056", cyc); end
        n_checks++; if (bus.pixel_ypos !== 11'd3) begin n_fail++; $display("FAIL ypos_third_line: got %0d expected 3", bus.pixel_ypos); end
    endtask

    // Now at h=0, v=37 of the first 7084 frame.
    task automatic test_id_change;
        int cyc;
        logic bl_prev;
        lcd_id = LCD_ID_7016;
        @(negedge lcd_clk);
        n_checks++; if (bus.h_disp !== 11'd800) begin n_fail++; $display("FAIL id_change_midframe: got h_disp %0d expected 800", bus.h_disp); end
        // Jump to the last line of the frame to keep the run short.
        force dut.v_cnt = 11'd524;
        @(negedge lcd_clk);
        release dut.v_cnt;
        cyc = 0; bl_prev = 1'b0;
        while (bus.frame_start !== 1'b1 && cyc < 3000) begin
            bl_prev = bus.lcd_bl;
            @(negedge lcd_clk);
            cyc++;
        end
        n_checks++; if (cyc != 1054) begin n_fail++; $display("FAIL last_line_length: got %0d expected 1054", cyc); end
        n_checks++; if (bus.h_disp !== 11'd1024) begin n_fail++; $display("FAIL h_disp_7016: got %0d expected 1024", bus.h_disp); end
        n_checks++; if (bus.v_disp !== 11'd600) begin n_fail++; $display("FAIL v_disp_7016: got %0d expected 600", bus.v_disp); end
        n_checks++; if (bl_prev !== 1'b0 || bus.lcd_bl !== 1'b1) begin n_fail++; $display("FAIL bl_rise: got before=%b after=%b expected 0 1", bl_prev, bus.lcd_bl); end
        count_hs_period(3000, cyc);
        n_checks++; if (cyc != 1344) begin n_fail++; $display("FAIL line_period_7016: got %0d expected 1344", cyc); end
    endtask

    task automatic test_4342;
        int cyc;
        logic [10:0] prev_x, max_x;
        sys_rst_n = 1'b0;
        lcd_id = LCD_ID_4342;
        repeat (2) @(negedge lcd_clk);
        release_and_wait_rst(cyc);
        @(negedge lcd_clk);
        n_checks++; if (bus.h_disp !== 11'd480) begin n_fail++; $display("FAIL h_disp_4342: got %0d expected 480", bus.h_disp); end
        n_checks++; if (bus.v_disp !== 11'd272) begin n_fail++; $display("FAIL v_disp_4342: got %0d expected 272", bus.v_disp); end
        cyc = 0; prev_x = 11'h7FF; max_x = '0;
        while (bus.lcd_de !== 1'b1 && cyc < 10000) begin
            prev_x = bus.pixel_xpos;
            @(negedge lcd_clk);
            cyc++;
        end
        n_checks++; if (cyc != 6343) begin n_fail++; $display("FAIL first_de_4342: got cycle %0d expected 6343", cyc); end
        n_checks++; if (prev_x !== 11'd0) begin n_fail++; $display("FAIL xpos_before_de_4342: got %0d expected 0", prev_x); end
        n_checks++; if (bus.pixel_ypos !== 11'd1) begin n_fail++; $display("FAIL ypos_first_4342: got %0d expected 1", bus.pixel_ypos); end
        cyc = 0;
        while (bus.lcd_de === 1'b1 && cyc < 2000) begin
            if (bus.pixel_xpos > max_x) max_x = bus.pixel_xpos;
            @(negedge lcd_clk);
            cyc++;
        end
        n_checks++; if (cyc != 480) begin n_fail++; $display("FAIL de_width_4342: got %0d expected 480", cyc); end
        n_checks++; if (max_x !== 11'd479) begin n_fail++; $display("FAIL xpos_max_4342: got %0d expected 479", max_x); end
        count_hs_period(2000, cyc);
        @(negedge lcd_clk);
        // Jump to the last active line (v = 12 + 272 - 1).
        force dut.v_cnt = 11'd283;
        @(negedge lcd_clk);
        release dut.v_cnt;
        n_checks++; if (bus.pixel_ypos !== 11'd272) begin n_fail++; $display("FAIL ypos_last_4342: got %0d expected 272", bus.pixel_ypos); end
        cyc = 0; prev_x = 11'h7FF;
        while (bus.lcd_de !== 1'b1 && cyc < 2000) begin
            prev_x = bus.pixel_xpos;
            @(negedge lcd_clk);
            cyc++;
        end
        n_checks++; if (cyc != 41) begin n_fail++; $display("FAIL de_last_line_4342: got %0d expected 41", cyc); end
        n_checks++; if (prev_x !== 11'd0) begin n_fail++; $display("FAIL xpos_before_de_last: got %0d expected 0", prev_x); end
        count_hs_period(2000, cyc);
        n_checks++; if (bus.pixel_ypos !== 11'd0) begin n_fail++; $display("FAIL ypos_after_active: got %0d expected 0", bus.pixel_ypos); end
    endtask

    task automatic test_unknown_id;
        int cyc;
        sys_rst_n = 1'b0;
        lcd_id = 16'hFFFF;
        repeat (2) @(negedge lcd_clk);
        release_and_wait_rst(cyc);
        @(negedge lcd_clk);
        n_checks++; if (bus.h_disp !== 11'd800 || bus.v_disp !== 11'd480) begin n_fail++; $display("FAIL unknown_id_size: got %0dx%0d expected 800x480", bus.h_disp, bus.v_disp); end
        count_hs_period(2000, cyc);
        n_checks++; if (cyc != 1056) begin n_fail++; $display("FAIL line_period_unknown: got %0d expected 1056", cyc); end
    endtask

    // Now at h=0, v=1 of an 800x480 frame.
    task automatic test_reset_midline;
        int cyc;
        repeat (10) @(negedge lcd_clk);
        n_checks++; if (bus.lcd_hs !== 1'b0 || bus.lcd_vs !== 1'b0) begin n_fail++; $display("FAIL pre_reset_sync: got hs=%b vs=%b expected 0 0", bus.lcd_hs, bus.lcd_vs); end
        #1 sys_rst_n = 1'b0;
        #1;
        n_checks++; if (bus.lcd_hs !== 1'b1 || bus.lcd_vs !== 1'b1) begin n_fail++; $display("FAIL async_sync: got hs=%b vs=%b expected 1 1", bus.lcd_hs, bus.lcd_vs); end
        n_checks++; if (bus.lcd_rst !== 1'b0) begin n_fail++; $display("FAIL async_lcd_rst: got %b expected 0", bus.lcd_rst); end
        n_checks++; if (bus.h_disp !== 11'd0 || bus.v_disp !== 11'd0) begin n_fail++; $display("FAIL async_disp: got %0dx%0d expected 0x0", bus.h_disp, bus.v_disp); end
        n_checks++; if (bus.lcd_de !== 1'b0 || bus.lcd_rgb !== 16'h0000) begin n_fail++; $display("FAIL async_de_rgb: got de=%b rgb=%h expected 0 0000", bus.lcd_de, bus.lcd_rgb); end
        @(negedge lcd_clk);
        release_and_wait_rst(cyc);
        n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL restart_lcd_rst: got cycle %0d expected 16", cyc); end
        @(negedge lcd_clk);
        n_checks++; if (bus.frame_start !== 1'b1 || bus.h_disp !== 11'd800) begin n_fail++; $display("FAIL restart_run: got fs=%b h_disp=%0d expected 1 800", bus.frame_start, bus.h_disp); end
    endtask

    initial begin
`ifdef LCD_TIMING_TEST_PATTERN_EN
        bus.test_pat_en = 1'b0;
`endif
        bus.lcd_data = 16'hF800;
        test_reset();
        test_startup_7084();
        test_first_de_7084();
        test_id_change();
        test_4342();
        test_unknown_id();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
